// File: rtl/lvds_rx_word_align_if.sv
// Parallel-side signals between the LVDS receiver/init sequencer and the word aligner.
interface lvds_rx_word_align_if #(
  parameter int DESER_FACTOR = 10,
  parameter int MAX_SLIPS    = 20
);
  logic                               init_done;
  logic [DESER_FACTOR-1:0]            rx_data;
  logic                               rx_bitslip;
  logic                               aligned;
  logic                               align_error;
  logic [$clog2(MAX_SLIPS+1)-1:0]     slip_count;

  modport master (output init_done, rx_data,
                  input  rx_bitslip, aligned, align_error, slip_count);
  modport slave  (input  init_done, rx_data,
                  output rx_bitslip, aligned, align_error, slip_count);
endinterface

// File: rtl/lvds_rx_word_align.sv
// Word aligner: pulses bitslip until the training word is seen MATCH_COUNT times in a row,
// then holds lock until LOSS_COUNT consecutive mismatches.
module lvds_rx_word_align #(
  parameter int                      DESER_FACTOR  = 10,
  parameter logic [DESER_FACTOR-1:0] TRAIN_PATTERN = DESER_FACTOR'(10'h3E0),
  parameter int                      MATCH_COUNT   = 16,
  parameter int                      BITSLIP_WAIT  = 4,
  parameter int                      MAX_SLIPS     = 20,
  parameter int                      LOSS_COUNT    = 4
) (
  input logic clk,
  input logic rst,
  lvds_rx_word_align_if.slave bus
);
  localparam int SCW = $clog2(MAX_SLIPS + 1);
  localparam int MCW = $clog2(MATCH_COUNT + 1);
  localparam int WCW = (BITSLIP_WAIT > 1) ? $clog2(BITSLIP_WAIT) : 1;
  localparam int LCW = $clog2(LOSS_COUNT + 1);

  localparam logic [MCW-1:0] MATCH_LAST = MCW'(MATCH_COUNT - 1);
  localparam logic [WCW-1:0] WAIT_LAST  = WCW'((BITSLIP_WAIT > 0) ? BITSLIP_WAIT - 1 : 0);
  localparam logic [LCW-1:0] LOSS_LAST  = LCW'(LOSS_COUNT - 1);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] CHECK  = 3'd1;
  localparam logic [2:0] SLIP   = 3'd2;
  localparam logic [2:0] WAIT   = 3'd3;
  localparam logic [2:0] LOCKED = 3'd4;
  localparam logic [2:0] FAIL   = 3'd5;

  logic [2:0]     state;
  logic [SCW-1:0] slip_cnt;
  logic [MCW-1:0] match_cnt;
  logic [WCW-1:0] wait_cnt;
  logic [LCW-1:0] loss_cnt;
  logic           bitslip_q, aligned_q, error_q;
  logic           hit;

  assign hit = (bus.rx_data == TRAIN_PATTERN);

  always_ff @(posedge clk) begin
    // Losing init_done anywhere past IDLE is treated exactly like a reset.
    if (rst || (state != IDLE && !bus.init_done)) begin
      state     <= IDLE;
      slip_cnt  <= '0;
      match_cnt <= '0;
      wait_cnt  <= '0;
      loss_cnt  <= '0;
      bitslip_q <= 1'b0;
      aligned_q <= 1'b0;
      error_q   <= 1'b0;
    end else begin
      bitslip_q <= 1'b0;
      case (state)
        IDLE: if (bus.init_done) begin
          state     <= CHECK;
          slip_cnt  <= '0;
          match_cnt <= '0;
          wait_cnt  <= '0;
          loss_cnt  <= '0;
        end
        CHECK: if (hit) begin
          if (match_cnt == MATCH_LAST) begin
            state     <= LOCKED;
            aligned_q <= 1'b1;
            match_cnt <= '0;
            loss_cnt  <= '0;
          end else begin
            match_cnt <= match_cnt + MCW'(1);
          end
        end else begin
          match_cnt <= '0;
          // The bound check also keeps slip_cnt from ever passing MAX_SLIPS.
          if (slip_cnt < SCW'(MAX_SLIPS)) begin
            state     <= SLIP;
            bitslip_q <= 1'b1;
            slip_cnt  <= slip_cnt + SCW'(1);
          end else begin
            state   <= FAIL;
            error_q <= 1'b1;
          end
        end
        SLIP: begin
          wait_cnt <= '0;
          state    <= (BITSLIP_WAIT == 0) ? CHECK : WAIT;
        end
        WAIT: if (wait_cnt == WAIT_LAST) begin
          state     <= CHECK;
          match_cnt <= '0;
          wait_cnt  <= '0;
        end else begin
          wait_cnt <= wait_cnt + WCW'(1);
        end
        LOCKED: if (hit) begin
          loss_cnt <= '0;
        end else if (loss_cnt == LOSS_LAST) begin
          state     <= CHECK;
          aligned_q <= 1'b0;
          slip_cnt  <= '0;
          match_cnt <= '0;
          wait_cnt  <= '0;
          loss_cnt  <= '0;
        end else begin
          loss_cnt <= loss_cnt + LCW'(1);
        end
        FAIL: begin
          aligned_q <= 1'b0;
          error_q   <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.rx_bitslip  = bitslip_q;
  assign bus.aligned     = aligned_q;
  assign bus.align_error = error_q;
  assign bus.slip_count  = slip_cnt;
endmodule
